// File: rtl/deser400_pkg.sv
// deser400_pkg: shared register map, calibration FSM states and helpers.
//   REG_*    : register bank addresses seen on the calibration bus
//   state_e  : calibration sequencer states
//   onehot4  : channel index to one-hot channel select
package deser400_pkg;
  localparam logic [3:0] REG_ENABLE = 4'd1;
  localparam logic [3:0] REG_PDPER  = 4'd2;
  localparam logic [3:0] REG_PHEN   = 4'd3;
  localparam logic [3:0] REG_PHWR   = 4'd4;
  localparam logic [3:0] REG_XORSUM = 4'd5;
  localparam logic [3:0] REG_PHSEL  = 4'd6;
  typedef enum logic [3:0] {
    S_IDLE, S_WR_PHEN, S_SETTLE, S_RD_PHSEL, S_RD_XOR, S_EVAL,
    S_WAIT_TRIG, S_LOCK_CH, S_WR_PHDIS, S_WR_EN, S_DONE
  } state_e;
  function automatic logic [3:0] onehot4(input logic [1:0] k);
    return 4'b0001 << k;
  endfunction
endpackage

// File: rtl/deser400_cal_lane.sv
// deser400_cal_lane: per-channel phase stability tracker.
//   clk, reset : clock, asynchronous active-low reset
//   clr        : start of a new sequence, clears all lane state
//   upd        : evaluate the current sample for this channel
//   nibble     : this channel's phsel sample
//   locked     : registered lock flag
//   lock_nxt   : lock flag as it will be after this cycle
module deser400_cal_lane #(
  parameter int STABLE = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       upd,
  input  logic [3:0] nibble,
  output logic       locked,
  output logic       lock_nxt
);
  localparam logic [2:0] STB = 3'(STABLE);
  logic [3:0] prev_q, prev_d;
  logic [2:0] cnt_q, cnt_d;
  logic       locked_q, locked_d, run;
  // a zero count marks "no sample yet", so the first sample always restarts at 1
  always_comb begin
    run      = upd & ~locked_q;
    prev_d   = clr ? 4'd0 : run ? nibble : prev_q;
    cnt_d    = clr ? 3'd0 : !run ? cnt_q :
               (cnt_q == 3'd0 || nibble != prev_q) ? 3'd1 :
               (cnt_q == STB) ? STB : cnt_q + 3'd1;
    locked_d = ~clr & (locked_q | (run & (cnt_d == STB)));
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q   <= '0;
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
    end
  end
  assign locked   = locked_q;
  assign lock_nxt = locked_d;
endmodule

// File: rtl/deser400_cal.sv
// deser400_cal: phase calibration sequencer driving the deserializer register bank.
//   clk, reset            : clock, asynchronous active-low reset
//   start, chan_mask      : calibration request and channels to calibrate
//   pd_trig               : phase detector trigger pulse
//   read, write, address,
//   writedata, readdata   : single-cycle register bus
//   busy, done            : sequence status, one-cycle completion pulse
//   locked, timeout_err   : per-channel lock result, timeout flag
//   phsel_out, xorsum_out : last phsel / xorsum values read
module deser400_cal
  import deser400_pkg::*;
#(
  parameter int SETTLE  = 4,
  parameter int STABLE  = 3,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  chan_mask,
  input  logic        pd_trig,
  output logic        read,
  output logic        write,
  output logic [3:0]  address,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        done,
  output logic [3:0]  locked,
  output logic        timeout_err,
  output logic [15:0] phsel_out,
  output logic [31:0] xorsum_out
);
  localparam int MX = SETTLE > TIMEOUT ? SETTLE : TIMEOUT;
  localparam int CW = $clog2(MX + 1);
  localparam logic [CW-1:0] SET_C = CW'(SETTLE);
  localparam logic [CW-1:0] TO_C  = CW'(TIMEOUT);
  localparam logic [CW-1:0] ONE   = CW'(1);
  state_e        state_q, state_d;
  logic [3:0]    mask_q, mask_d, lock_nxt, upd_v;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   phsel_q, phsel_d;
  logic [31:0]   xorsum_q, xorsum_d, writedata_q, writedata_d;
  logic [3:0]    address_q, address_d;
  logic          read_q, read_d, write_q, write_d, busy_q, busy_d, done_q, done_d;
  logic          terr_q, terr_d, clr, upd, wr_lock;
  assign cnt_inc = cnt_q + ONE;
  assign upd_v   = {4{upd}} & mask_q;
  genvar i;
  for (i = 0; i < 4; i++) begin : g_lane
    deser400_cal_lane #(.STABLE(STABLE)) u_lane (
      .clk(clk), .reset(reset), .clr(clr), .upd(upd_v[i]),
      .nibble(phsel_q[4*i +: 4]), .locked(locked[i]), .lock_nxt(lock_nxt[i])
    );
  end
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    phsel_d  = phsel_q;
    xorsum_d = xorsum_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    terr_d   = terr_q;
    clr      = 1'b0;
    upd      = 1'b0;
    unique case (state_q)
      // the done cycle is already IDLE, so a start coinciding with done is masked here
      S_IDLE: if (start && !done_q) begin
        clr     = 1'b1;
        mask_d  = chan_mask;
        terr_d  = 1'b0;
        busy_d  = 1'b1;
        state_d = chan_mask == 4'd0 ? S_DONE : S_WR_PHEN;
      end
      S_WR_PHEN: begin
        cnt_d   = '0;
        state_d = SETTLE == 0 ? S_RD_PHSEL : S_SETTLE;
      end
      // the counter is reused: cleared after settling, then counts timeout triggers
      S_SETTLE: if (pd_trig) begin
        cnt_d   = cnt_inc == SET_C ? '0 : cnt_inc;
        state_d = cnt_inc == SET_C ? S_RD_PHSEL : S_SETTLE;
      end
      S_RD_PHSEL: begin
        phsel_d = readdata[15:0];
        state_d = S_RD_XOR;
      end
      S_RD_XOR: begin
        xorsum_d = readdata;
        state_d  = S_EVAL;
      end
      S_EVAL: begin
        upd     = 1'b1;
        idx_d   = 2'd0;
        state_d = (lock_nxt & mask_q) == mask_q ? S_LOCK_CH : S_WAIT_TRIG;
      end
      S_WAIT_TRIG: if (pd_trig) begin
        cnt_d   = cnt_q == TO_C ? TO_C : cnt_inc;
        terr_d  = cnt_inc == TO_C;
        state_d = cnt_inc == TO_C ? S_LOCK_CH : S_RD_PHSEL;
      end
      S_LOCK_CH: begin
        idx_d   = idx_q + 2'd1;
        state_d = idx_q == 2'd3 ? S_WR_PHDIS : S_LOCK_CH;
      end
      S_WR_PHDIS: state_d = S_WR_EN;
      S_WR_EN:    state_d = S_DONE;
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // bus strobes are registered from the next state so they line up with that state's cycle
    wr_lock     = state_d == S_LOCK_CH && lock_nxt[idx_d];
    read_d      = state_d == S_RD_PHSEL || state_d == S_RD_XOR;
    write_d     = wr_lock || state_d == S_WR_PHEN || state_d == S_WR_PHDIS || state_d == S_WR_EN;
    address_d   = state_d == S_RD_PHSEL ? REG_PHSEL :
                  state_d == S_RD_XOR ? REG_XORSUM :
                  (state_d == S_WR_PHEN || state_d == S_WR_PHDIS) ? REG_PHEN :
                  state_d == S_WR_EN ? REG_ENABLE :
                  wr_lock ? REG_PHWR : 4'd0;
    writedata_d = state_d == S_WR_PHEN ? {28'd0, mask_d} :
                  state_d == S_WR_EN ? {28'd0, lock_nxt} :
                  wr_lock ? {24'd0, onehot4(idx_d), phsel_d[{idx_d, 2'b00} +: 4]} : 32'd0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      mask_q      <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      phsel_q     <= '0;
      xorsum_q    <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      address_q   <= '0;
      writedata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      phsel_q     <= phsel_d;
      xorsum_q    <= xorsum_d;
      read_q      <= read_d;
      write_q     <= write_d;
      address_q   <= address_d;
      writedata_q <= writedata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      terr_q      <= terr_d;
    end
  end
  assign read        = read_q;
  assign write       = write_q;
  assign address     = address_q;
  assign writedata   = writedata_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = terr_q;
  assign phsel_out   = phsel_q;
  assign xorsum_out  = xorsum_q;
endmodule

// File: tb/tb_deser400_cal.sv
// tb_deser400_cal: scoreboard bench for the calibration sequencer with a register bank model.
module tb_deser400_cal;
  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, pd_trig = 1'b0;
  logic [3:0]  chan_mask = 4'd0;
  logic        read, write, busy, done, timeout_err;
  logic [3:0]  address, locked;
  logic [31:0] writedata, readdata, xorsum_out;
  logic [15:0] phsel_out;
  int compared = 0, mismatched = 0;
  int nsamp = 0, samp_base = 0, done_cnt = 0, scn = 0, pdc = 0;
  localparam logic [31:0] XB = 32'hA5A5_0000;
  typedef struct {
    logic [3:0]  lk;
    logic        te;
    int          ns;
    logic [15:0] ph;
    bit          chk;
  } res_t;
  logic [35:0] wq[$];
  res_t        rq[$];
  logic [35:0] mon_e;
  res_t        mon_r;

  deser400_cal #(.SETTLE(4), .STABLE(3), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .start(start), .chan_mask(chan_mask), .pd_trig(pd_trig),
    .read(read), .write(write), .address(address), .writedata(writedata), .readdata(readdata),
    .busy(busy), .done(done), .locked(locked), .timeout_err(timeout_err),
    .phsel_out(phsel_out), .xorsum_out(xorsum_out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ph_for(input int s, input int n);
    return s == 1 ? 16'h8421 :
           s == 2 ? {8'h00, ((n % 2 == 1) ? 4'h6 : 4'h5), 4'h1} :
           s == 3 ? ((n == 0) ? 16'h0002 : 16'h0003) :
           ((n % 2 == 1) ? 16'h1111 : 16'h2222);
  endfunction

  assign readdata = !read ? 32'd0 :
                    address == 4'd6 ? {16'd0, ph_for(scn, nsamp - samp_base)} :
                    address == 4'd5 ? (XB ^ 32'(nsamp)) : 32'd0;
  always @(posedge clk) if (read && address == 4'd6) nsamp <= nsamp + 1;

  initial forever begin
    @(negedge clk);
    pdc = (pdc == 5) ? 0 : pdc + 1;
    pd_trig = (pdc == 0);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) if (reset) begin
    chk("rw_exclusive", 64'(read & write), 64'd0);
    if (!read && !write) chk("idle_bus", {address, writedata}, 64'd0);
    if (write) begin
      if (wq.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none", address, writedata);
      end else begin
        mon_e = wq.pop_front();
        chk("bus_write", {address, writedata}, 64'(mon_e));
      end
    end
    if (done) begin
      done_cnt++;
      if (rq.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got done expected none");
      end else begin
        mon_r = rq.pop_front();
        chk("done_locked", 64'(locked), 64'(mon_r.lk));
        chk("done_timeout_err", 64'(timeout_err), 64'(mon_r.te));
        chk("done_samples", 64'(nsamp - samp_base), 64'(mon_r.ns));
        chk("writes_drained", 64'(wq.size()), 64'd0);
        if (mon_r.chk) begin
          chk("phsel_out", 64'(phsel_out), 64'(mon_r.ph));
          chk("xorsum_out", 64'(xorsum_out), 64'(XB ^ 32'(nsamp)));
        end
      end
    end
  end

  task automatic exp_seq(input logic [3:0] m, input logic [3:0] lk, input logic te,
                         input int ns, input logic [15:0] ph);
    res_t r;
    wq.push_back({4'd3, 28'd0, m});
    for (int k = 0; k < 4; k++)
      if (lk[k]) wq.push_back({4'd4, 24'd0, 4'(1 << k), ph[4*k +: 4]});
    wq.push_back({4'd3, 32'd0});
    wq.push_back({4'd1, 28'd0, lk});
    r.lk = lk; r.te = te; r.ns = ns; r.ph = ph; r.chk = 1'b1;
    rq.push_back(r);
  endtask

  task automatic go(input int s, input logic [3:0] m);
    @(negedge clk);
    scn = s;
    samp_base = nsamp;
    chan_mask = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int n0;
    int i;
    n0 = done_cnt;
    i = 0;
    while (done_cnt == n0 && i < lim) begin
      @(negedge clk);
      i++;
    end
    if (done_cnt == n0) begin
      compared++;
      mismatched++;
      $display("FAIL wait_done: got no done expected one within %0d cycles", lim);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    res_t z;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {busy, done, read, write, address, locked, timeout_err}, 64'd0);
    chk("reset_wdata", 64'(writedata), 64'd0);
    chk("reset_obs", {phsel_out, xorsum_out}, 64'd0);
    @(negedge clk) reset = 1'b1;
    // all channels stable from the first sample
    exp_seq(4'hF, 4'hF, 1'b0, 3, 16'h8421);
    go(1, 4'hF);
    wait_done(400);
    // channel II toggles, channel I stable, sequence times out
    exp_seq(4'h3, 4'h1, 1'b1, 8, 16'h0061);
    go(2, 4'h3);
    wait_done(600);
    // channel I settles late: 2,3,3,3
    exp_seq(4'h1, 4'h1, 1'b0, 4, 16'h0003);
    go(3, 4'h1);
    wait_done(400);
    // second start mid-sequence must not disturb it
    exp_seq(4'hF, 4'hF, 1'b0, 3, 16'h8421);
    go(1, 4'hF);
    repeat (8) @(negedge clk);
    chan_mask = 4'h1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_held", 64'(busy), 64'd1);
    wait_done(400);
    // zero mask: done two cycles after start, then a start during done is ignored
    z.lk = 4'd0; z.te = 1'b0; z.ns = 0; z.ph = 16'd0; z.chk = 1'b0;
    rq.push_back(z);
    go(0, 4'h0);
    chk("zero_mask_not_yet", 64'(done), 64'd0);
    @(negedge clk);
    chk("zero_mask_done", 64'(done), 64'd1);
    chk("zero_mask_busy", 64'(busy), 64'd0);
    chan_mask = 4'hF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_on_done_ignored", 64'(busy), 64'd0);
    repeat (20) @(negedge clk);
    chk("still_idle", {busy, done}, 64'd0);
    // reset while waiting for a trigger
    wq.push_back({4'd3, 28'd0, 4'hF});
    go(4, 4'hF);
    for (int i = 0; i < 200 && !(read && address == 4'd5); i++) @(negedge clk);
    chk("reach_rd_xor", {read, address}, {1'b1, 4'd5});
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wq.delete();
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_bus", {read, write}, 64'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    exp_seq(4'hF, 4'hF, 1'b0, 3, 16'h8421);
    go(1, 4'hF);
    wait_done(400);
    chk("queues_empty", 64'(wq.size() + rq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 20000 cycles");
    $fatal(1, "simulation time limit");
  end
endmodule

// File: doc/deser400_cal.md
DESER400_CAL -- requirements
Module: deser400_cal

Interface
REQ-001 Parameter SETTLE, default 4, number of pd_trig pulses to wait after phase detector enable before the first sample.
REQ-002 Parameter STABLE, default 3, number of consecutive equal phsel samples that lock a channel (range 1..7).
REQ-003 Parameter TIMEOUT, default 64, maximum number of pd_trig pulses counted from the first sample before the sequence aborts.
REQ-004 The block SHALL have one clock, and reset SHALL be asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock; the register bank's clock.
REQ-006 reset  in  1  asynchronous active-low reset.
REQ-007 start  in  1  one-cycle request to calibrate; ignored while busy=1.
REQ-008 chan_mask  in  4  channels to calibrate, bit0=I .. bit3=IV; sampled on the start cycle.
REQ-009 pd_trig  in  1  one-cycle phase detector trigger pulse from the register bank.
REQ-010 read  out  1  bus read strobe.
REQ-011 write  out  1  bus write strobe.
REQ-012 address  out  4  bus register address.
REQ-013 writedata  out  32  bus write data.
REQ-014 readdata  in  32  bus read data, combinationally valid in the cycle read=1.
REQ-015 busy  out  1  sequence in progress.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 locked  out  4  per-channel lock result, valid from done until the next start.
REQ-018 timeout_err  out  1  the last sequence ended by timeout.
REQ-019 phsel_out  out  16  last phsel read {IV,III,II,I}.
REQ-020 xorsum_out  out  32  last xorsum read {IV,III,II,I}.

Function
REQ-021 Bus access rules: at most one of read or write is high in any cycle, every access takes one cycle, there is no wait state, and address and writedata are 0 when idle.
REQ-022 FSM states: IDLE -> WR_PHEN -> SETTLE -> RD_PHSEL -> RD_XOR -> EVAL -> WAIT_TRIG -> (RD_PHSEL | LOCK_CH) -> WR_PHDIS -> WR_EN -> DONE -> IDLE.
REQ-023 IDLE: on start with chan_mask!=0, capture the mask, clear locked, clear timeout_err, set busy, and go to WR_PHEN.
REQ-024 IDLE, mask=0: on start with chan_mask=0, go to DONE with no bus access; locked=0 and timeout_err=0.
REQ-025 WR_PHEN: write address 3 with writedata={28'd0,mask}.
REQ-026 SETTLE: count SETTLE pd_trig pulses, then go to RD_PHSEL.
REQ-027 RD_PHSEL: read address 3'd6 and capture readdata[15:0] into phsel_out.
REQ-028 RD_XOR: read address 5 and capture readdata into xorsum_out.
REQ-029 EVAL, per masked unlocked channel: if its nibble equals the previous sample, increment its count, saturating at STABLE; otherwise reset its count to 1; the first sample sets the count to 1.
REQ-030 EVAL lock: a channel is locked when its count equals STABLE, and a locked channel stays locked for the rest of the sequence.
REQ-031 EVAL exit: if all masked channels are locked, go to LOCK_CH; otherwise go to WAIT_TRIG.
REQ-032 Timeout counter: counts pd_trig pulses seen in WAIT_TRIG and saturates at TIMEOUT.
REQ-033 WAIT_TRIG: on a pd_trig pulse, go to RD_PHSEL; if that pulse brings the count to TIMEOUT, go to LOCK_CH instead and set timeout_err=1.
REQ-034 pd_trig pulses arriving outside SETTLE and WAIT_TRIG SHALL be ignored.
REQ-035 LOCK_CH: iterate channel index 0..3, spending one cycle per index.
REQ-036 LOCK_CH write: for a locked index k, write address 4 with writedata={24'd0, onehot(k), phsel nibble k}; for an unlocked index, do not access the bus.
REQ-037 WR_PHDIS: write address 3 with writedata=0.
REQ-038 WR_EN: write address 1 with writedata={28'd0,locked}.
REQ-039 DONE: pulse done for one cycle, clear busy, and return to IDLE.
REQ-040 A start arriving in the same cycle that done is high SHALL be ignored.
REQ-041 Latency without timeout, measured in cycles from start to done: 1 + SETTLE-wait + 3 per sample + trigger waits + 4 + 2 + 1.

Reset
REQ-042 While reset=0, all outputs SHALL be 0, the FSM SHALL be in IDLE, and all counters and lane state SHALL be cleared.
REQ-043 A reset in mid-sequence SHALL abort the sequence immediately with no further bus access; the register bank is reset by the same signal.

Structure
REQ-044 Shared package deser400_pkg SHALL hold the register address constants (REG_ENABLE=1, REG_PDPER=2, REG_PHEN=3, REG_PHWR=4, REG_XORSUM=5, REG_PHSEL=6) and the FSM state enum.
REQ-045 The block SHALL contain one sub-module, deser400_cal_lane, instantiated 4 times, holding the previous nibble, the stability count and the locked flag for one channel.

Verification
REQ-046 Scenario, all stable: mask=4'hF with phsel constant at 16'h8421 -> 3 samples, then writes to address 4 of 0x11, 0x22, 0x44, 0x88, then address 3 <- 0, then address 1 <- 0xF; locked=4'hF, timeout_err=0.
REQ-047 Scenario, one channel unstable: mask=4'h3 with channel II toggling 5/6 every sample and TIMEOUT=8 -> timeout_err=1, locked=4'h1, only address 4 <- 0x1?; address 1 <- 0x1.
REQ-048 Scenario, late stability: channel I samples 2,3,3,3 -> lock after the 4th sample; an address 4 write occurs with phdata=3.
REQ-049 Scenario, start while busy and zero mask: a second start mid-sequence has no effect; start with mask=0 -> done two cycles later with no bus activity.
REQ-050 Scenario, reset mid-sequence: reset asserted during WAIT_TRIG -> next cycle busy=0 and read=write=0; a new start after release runs a full sequence.
REQ-051 The bench SHALL check in every cycle that read and write are never high together.
